// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer
//   Command sequencer for a shared combinational calculator datapath.
//   Commands are buffered in a FIFO and issued one at a time. Each command
//   holds the calculator inputs for SETTLE cycles. The result and flags are
//   then captured and returned in order, together with an error tag and an
//   8-bit sequence number.
//
// Ports
//   clock, reset       rising-edge clock, synchronous active-high reset
//   cmd_valid/ready    command handshake; cmd_ready = (fifo_count != DEPTH)
//   cmd_op/a/b         operation code and operands
//   alu_op_select,
//   alu_operand1/2     drive the calculator (0 when idle or for errors)
//   alu_resultado,
//   alu_banderas       calculator result (2*NBITS) and flags (4)
//   rsp_valid/ready    response handshake
//   rsp_result/flags   captured calculator outputs
//   rsp_error          illegal op, or divide/modulo by zero
//   rsp_seq            response sequence number, wraps at 255
//   busy               FSM not idle or FIFO not empty
//   fifo_count         FIFO occupancy
module calc_op_sequencer #(
    parameter int NBITS  = 4,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_op,
    input  logic [NBITS-1:0]         cmd_a,
    input  logic [NBITS-1:0]         cmd_b,
    output logic [3:0]               alu_op_select,
    output logic [NBITS-1:0]         alu_operand1,
    output logic [NBITS-1:0]         alu_operand2,
    input  logic [2*NBITS-1:0]       alu_resultado,
    input  logic [3:0]               alu_banderas,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [2*NBITS-1:0]       rsp_result,
    output logic [3:0]               rsp_flags,
    output logic                     rsp_error,
    output logic [7:0]               rsp_seq,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DRIVE   = 2'd1;
    localparam logic [1:0] ST_RESPOND = 2'd2;

    logic [3:0]       fifo_op [DEPTH];
    logic [NBITS-1:0] fifo_a  [DEPTH];
    logic [NBITS-1:0] fifo_b  [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;

    logic [1:0]       state;
    logic [3:0]       settle_cnt;
    logic [3:0]       iss_op;
    logic [NBITS-1:0] iss_a, iss_b;
    logic             iss_err;

    logic             push, pop, head_err, drive_en;

    assign cmd_ready  = (count != CW'(DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state == ST_IDLE) && (count != '0);
    assign fifo_count = count;
    assign busy       = (state != ST_IDLE) || (count != '0);

    // An error is decided once, at pop time, from the head entry.
    assign head_err = (fifo_op[rd_ptr] > 4'd9) ||
                      (((fifo_op[rd_ptr] == 4'd3) || (fifo_op[rd_ptr] == 4'd4)) &&
                       (fifo_b[rd_ptr] == '0));

    // The calculator sees the issued command only in DRIVE. It sees zeros
    // for erroring commands so the shared datapath never divides by zero.
    assign drive_en      = (state == ST_DRIVE) && !iss_err;
    assign alu_op_select = drive_en ? iss_op : '0;
    assign alu_operand1  = drive_en ? iss_a  : '0;
    assign alu_operand2  = drive_en ? iss_b  : '0;

    // Storage needs no reset; only pointers and count define contents.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_op[wr_ptr] <= cmd_op;
            fifo_a[wr_ptr]  <= cmd_a;
            fifo_b[wr_ptr]  <= cmd_b;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            iss_op     <= '0;
            iss_a      <= '0;
            iss_b      <= '0;
            iss_err    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_error  <= 1'b0;
            rsp_seq    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        iss_op     <= fifo_op[rd_ptr];
                        iss_a      <= fifo_a[rd_ptr];
                        iss_b      <= fifo_b[rd_ptr];
                        iss_err    <= head_err;
                        settle_cnt <= 4'(SETTLE);
                        state      <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                    if (settle_cnt == 4'd1) begin
                        rsp_valid  <= 1'b1;
                        rsp_result <= iss_err ? '0 : alu_resultado;
                        rsp_flags  <= iss_err ? '0 : alu_banderas;
                        rsp_error  <= iss_err;
                        state      <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_seq   <= rsp_seq + 8'd1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
